// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired Moore control unit for the bus-based CPU. Each instruction is
// fetched in T0-T2 and executed in T3-T7. The unit drives the register-field
// selects, the datapath strobes, the ALU op and the memory Read/Write handshake.
// The opcode is decoded from IR[31:27]. A HALT instruction parks the unit
// until the next reset.
//
// Ports
//   clk, reset          rising-edge clock; synchronous active-high reset
//   IR                  instruction register (only [31:27] is decoded)
//   CON                 branch-condition flag, sampled in br T6
//   mem_done            memory completes the pending Read/Write this cycle
//   Gra, Grb, Grc       register-field select masks (4'hF when active)
//   Rin, Rout, BAout    register-file strobes
//   PCout ... CONin     datapath strobes
//   Read, Write         memory request, held until mem_done
//   alu_op              0=ADD 1=SUB 2=AND 3=OR (0 when Zin is low)
//   run                 1 while sequencing, 0 when halted or in reset
//   illegal             one-cycle pulse in T3 for an unsupported opcode
//
// state | meaning
// ------+---------------------------------------------------------
// T0    | PC -> MAR, PC+1 -> Z
// T1    | Z -> PC, start instruction read (first cycle)
// T1W   | instruction read still waiting for mem_done
// T2    | MDR -> IR
// T3-T7 | execute steps, selected by opcode
// HALT  | parked, all strobes low, left only by reset
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     IR,
  input  logic            CON,
  input  logic            mem_done,
  output logic [3:0]      Gra,
  output logic [3:0]      Grb,
  output logic [3:0]      Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Cout,
  output logic            CONin,
  output logic            Read,
  output logic            Write,
  output logic [ALUW-1:0] alu_op,
  output logic            run,
  output logic            illegal
);

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b01001;
  localparam logic [OPW-1:0] OP_OR   = 5'b01010;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
  localparam logic [OPW-1:0] OP_HALT = 5'b11010;

  localparam logic [ALUW-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUW-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUW-1:0] ALU_AND = 4'd2;
  localparam logic [ALUW-1:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [OPW-1:0] opcode;
  logic           is_alu, is_imm, is_ld, is_st, is_br, is_nop, is_halt, legal;
  logic [ALUW-1:0] alu_sel;
  logic           unused_ir;

  assign opcode    = IR[31:32-OPW];
  assign unused_ir = ^IR[31-OPW:0];

  assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
  assign is_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign is_ld   = (opcode == OP_LD);
  assign is_st   = (opcode == OP_ST);
  assign is_br   = (opcode == OP_BR);
  assign is_nop  = (opcode == OP_NOP);
  assign is_halt = (opcode == OP_HALT);
  assign legal   = is_alu || is_imm || is_ld || is_st || is_br || is_nop || is_halt;

  // Register and immediate forms share the same ALU function mapping.
  always_comb begin
    alu_sel = ALU_ADD;
    case (opcode)
      OP_SUB:          alu_sel = ALU_SUB;
      OP_AND, OP_ANDI: alu_sel = ALU_AND;
      OP_OR,  OP_ORI:  alu_sel = ALU_OR;
      default:         alu_sel = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_T0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_T0:   state_nxt = S_T1;
      S_T1,
      S_T1W:  state_nxt = mem_done ? S_T2 : S_T1W;
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        if (is_halt)                                      state_nxt = S_HALT;
        else if (is_alu || is_imm || is_ld || is_st || is_br) state_nxt = S_T4;
        else                                              state_nxt = S_T0;
      end
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = (is_ld || is_st || is_br) ? S_T6 : S_T0;
      S_T6: begin
        if (is_ld)      state_nxt = mem_done ? S_T7 : S_T6;
        else if (is_st) state_nxt = S_T7;
        else            state_nxt = S_T0;
      end
      S_T7: begin
        if (is_st) state_nxt = mem_done ? S_T0 : S_T7;
        else       state_nxt = S_T0;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_T0;
    endcase
  end

  // Reset overrides the whole decode so strobes drop in the same cycle,
  // even in the middle of a memory wait.
  always_comb begin
    Gra = 4'h0; Grb = 4'h0; Grc = 4'h0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    Zlowout = 1'b0; Cout = 1'b0; CONin = 1'b0;
    Read = 1'b0; Write = 1'b0;
    alu_op = ALU_ADD; run = 1'b0; illegal = 1'b0;
    if (!reset) begin
      run = (state != S_HALT);
      case (state)
        S_T0: begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; alu_op = ALU_ADD;
        end
        S_T1: begin
          Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = mem_done;
        end
        // PC was already loaded on the first T1 cycle; only the read is held.
        S_T1W: begin
          Zlowout = 1'b1; Read = 1'b1; MDRin = mem_done;
        end
        S_T2: begin
          MDRout = 1'b1; IRin = 1'b1;
        end
        S_T3: begin
          if (is_alu || is_imm) begin
            Grb = 4'hF; Rout = 1'b1; Yin = 1'b1;
          end else if (is_ld || is_st) begin
            Grb = 4'hF; BAout = 1'b1; Yin = 1'b1;
          end else if (is_br) begin
            Gra = 4'hF; Rout = 1'b1; CONin = 1'b1;
          end else if (!legal) begin
            illegal = 1'b1;
          end
        end
        S_T4: begin
          if (is_alu) begin
            Grc = 4'hF; Rout = 1'b1; Zin = 1'b1; alu_op = alu_sel;
          end else if (is_imm) begin
            Cout = 1'b1; Zin = 1'b1; alu_op = alu_sel;
          end else if (is_ld || is_st) begin
            Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD;
          end else if (is_br) begin
            PCout = 1'b1; Yin = 1'b1;
          end
        end
        S_T5: begin
          if (is_alu || is_imm) begin
            Zlowout = 1'b1; Gra = 4'hF; Rin = 1'b1;
          end else if (is_ld || is_st) begin
            Zlowout = 1'b1; MARin = 1'b1;
          end else if (is_br) begin
            Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD;
          end
        end
        S_T6: begin
          if (is_ld) begin
            Read = 1'b1; MDRin = mem_done;
          end else if (is_st) begin
            Gra = 4'hF; Rout = 1'b1; MDRin = 1'b1;
          end else if (is_br && CON) begin
            Zlowout = 1'b1; PCin = 1'b1;
          end
        end
        S_T7: begin
          if (is_ld) begin
            MDRout = 1'b1; Gra = 4'hF; Rin = 1'b1;
          end else if (is_st) begin
            Write = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer. A per-instruction model expands each
// opcode into its expected cycle-by-cycle strobe pattern (plus the mem_done
// and CON values to drive), then the bench replays it against the DUT.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic        CON, mem_done;
  logic [3:0]  Gra, Grb, Grc;
  logic        Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout;
  logic        IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write, run, illegal;
  logic [3:0]  alu_op;

  control_sequencer dut (
    .clk(clk), .reset(reset), .IR(IR), .CON(CON), .mem_done(mem_done),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Cout(Cout), .CONin(CONin), .Read(Read), .Write(Write), .alu_op(alu_op),
    .run(run), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [34:0] obs;
  assign obs = {alu_op, illegal, run, Write, Read, CONin, Cout, Zlowout, Zin, Yin,
                IRin, MDRout, MDRin, MARin, IncPC, PCin, PCout, BAout, Rout, Rin,
                Grc, Grb, Gra};

  localparam logic [34:0] GRA    = 35'h00000000F;
  localparam logic [34:0] GRB    = 35'h0000000F0;
  localparam logic [34:0] GRC    = 35'h000000F00;
  localparam logic [34:0] RIN    = 35'd1 << 12;
  localparam logic [34:0] ROUT   = 35'd1 << 13;
  localparam logic [34:0] BAOUT  = 35'd1 << 14;
  localparam logic [34:0] PCOUT  = 35'd1 << 15;
  localparam logic [34:0] PCIN   = 35'd1 << 16;
  localparam logic [34:0] INCPC  = 35'd1 << 17;
  localparam logic [34:0] MARIN  = 35'd1 << 18;
  localparam logic [34:0] MDRIN  = 35'd1 << 19;
  localparam logic [34:0] MDROUT = 35'd1 << 20;
  localparam logic [34:0] IRIN   = 35'd1 << 21;
  localparam logic [34:0] YIN    = 35'd1 << 22;
  localparam logic [34:0] ZIN    = 35'd1 << 23;
  localparam logic [34:0] ZLOW   = 35'd1 << 24;
  localparam logic [34:0] COUT   = 35'd1 << 25;
  localparam logic [34:0] CONIN  = 35'd1 << 26;
  localparam logic [34:0] READ   = 35'd1 << 27;
  localparam logic [34:0] WRITE  = 35'd1 << 28;
  localparam logic [34:0] RUN    = 35'd1 << 29;
  localparam logic [34:0] ILL    = 35'd1 << 30;

  function automatic logic [34:0] alu(input int v);
    return 35'(v) << 31;
  endfunction

  int nvec = 0;
  int nerr = 0;
  bit started = 0;

  logic [34:0] exp_q[$];
  bit          md_q[$];
  bit          con_q[$];

  // Raw entry: expected outputs plus the mem_done and CON to drive that cycle.
  task automatic q(input logic [34:0] e, input bit md, input bit c);
    exp_q.push_back(e); md_q.push_back(md); con_q.push_back(c);
  endtask

  // Ordinary running cycle: mem_done and CON are don't-care and randomised.
  task automatic p(input logic [34:0] e);
    q(e | RUN, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Memory phase: d wait cycles before mem_done; 'first' only on the first
  // cycle, 'done' only on the completing cycle.
  task automatic mem(input logic [34:0] base, input logic [34:0] first,
                     input logic [34:0] done, input int d);
    for (int i = 0; i <= d; i++)
      q(base | RUN | ((i == 0) ? first : '0) | ((i == d) ? done : '0),
        (i == d), 1'($urandom_range(0, 1)));
  endtask

  task automatic build(input logic [4:0] op, input bit con, input int d1, input int dm);
    exp_q.delete(); md_q.delete(); con_q.delete();
    p(PCOUT | MARIN | INCPC | ZIN | alu(0));
    mem(ZLOW | READ, PCIN, MDRIN, d1);
    p(MDROUT | IRIN);
    case (op)
      5'b00011, 5'b00100, 5'b01001, 5'b01010: begin
        p(GRB | ROUT | YIN);
        p(GRC | ROUT | ZIN | alu(op == 5'b00011 ? 0 : op == 5'b00100 ? 1 :
                                 op == 5'b01001 ? 2 : 3));
        p(ZLOW | GRA | RIN);
      end
      5'b01011, 5'b01100, 5'b01101: begin
        p(GRB | ROUT | YIN);
        p(COUT | ZIN | alu(op == 5'b01011 ? 0 : op == 5'b01100 ? 2 : 3));
        p(ZLOW | GRA | RIN);
      end
      5'b00000: begin
        p(GRB | BAOUT | YIN); p(COUT | ZIN | alu(0)); p(ZLOW | MARIN);
        mem(READ, '0, MDRIN, dm);
        p(MDROUT | GRA | RIN);
      end
      5'b00010: begin
        p(GRB | BAOUT | YIN); p(COUT | ZIN | alu(0)); p(ZLOW | MARIN);
        p(GRA | ROUT | MDRIN);
        mem(WRITE, '0, '0, dm);
      end
      5'b10010: begin
        p(GRA | ROUT | CONIN); p(PCOUT | YIN); p(COUT | ZIN | alu(0));
        q(RUN | (con ? (ZLOW | PCIN) : '0), 1'($urandom_range(0, 1)), con);
      end
      5'b11001: p('0);
      5'b11010: begin
        p('0);
        for (int i = 0; i < 20; i++) q('0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      default: p(ILL);
    endcase
  endtask

  task automatic check(input logic [34:0] e, input string tag, input int cyc);
    nvec++;
    assert (obs === e) else begin
      nerr++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, e);
    end
  endtask

  task automatic reset_cycle(input string tag);
    reset = 1'b1; mem_done = 1'b0;
    @(negedge clk); check('0, tag, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Caller is 1 time unit after a rising edge with the DUT in T0.
  task automatic run_instr(input logic [4:0] op, input bit con, input int d1,
                           input int dm, input int abort_at, input string tag);
    build(op, con, d1, dm);
    IR = {op, 27'($urandom)};
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        reset_cycle({tag, "_reset_abort"});
        break;
      end
      mem_done = md_q[i];
      CON = con_q[i];
      @(negedge clk); check(exp_q[i], tag, i);
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      nvec++;
      assert ((3'(Rout) + 3'(BAout) + 3'(PCout) + 3'(MDRout) + 3'(Zlowout) + 3'(Cout)) <= 3'd1)
      else begin
        nerr++;
        $error("FAIL bus_drivers: observed %h required at most one driver", obs);
      end
      nvec++;
      assert (!(Read && Write)) else begin
        nerr++;
        $error("FAIL read_write: observed Read=%b Write=%b required not both", Read, Write);
      end
    end
  end

  initial begin
    logic [4:0] op;
    reset = 1'b1; IR = '0; CON = 1'b0; mem_done = 1'b0;
    @(posedge clk); #1;
    started = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check('0, "reset", i);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    run_instr(5'b00011, 1'b0, 0, 0, -1, "add_direct");
    run_instr(5'b00000, 1'b0, 3, 3, -1, "ld_delay3");
    run_instr(5'b10010, 1'b0, 0, 0, -1, "br_con0");
    run_instr(5'b10010, 1'b1, 0, 0, -1, "br_con1");
    run_instr(5'b00010, 1'b0, 1, 2, -1, "st_delay");
    run_instr(5'b11111, 1'b0, 0, 0, -1, "illegal_11111");
    run_instr(5'b11001, 1'b0, 0, 0, -1, "nop");
    run_instr(5'b11010, 1'b0, 0, 0, -1, "halt");
    reset_cycle("halt_reset");
    run_instr(5'b00100, 1'b0, 0, 0, -1, "sub_after_halt");
    run_instr(5'b00010, 1'b0, 0, 5, 9, "st_t7_abort");
    run_instr(5'b01100, 1'b0, 0, 0, -1, "andi_after_abort");

    for (int n = 0; n < 60; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11010) op = 5'b11001;
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                $urandom_range(0, 4), -1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
